// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32 decode stage: opcodes, TYPES bit positions
// and the decoded operand-select bundle handed to execute.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int T_R = 6;
  localparam int T_I = 5;
  localparam int T_L = 4;
  localparam int T_S = 3;
  localparam int T_J = 2;
  localparam int T_B = 1;
  localparam int T_U = 0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      types;
    logic            illegal;
  } decoded_t;

endpackage

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32 instruction decoder producing the operand-select
// bundle; unused register fields and funct7 are zeroed so execute sees clean values.
module rv32_decode_comb
  import rv32_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decoded_t        bundle
);

  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a latch.
    bundle        = '0;
    bundle.pc     = pc;
    bundle.opcode = instr[6:0];
    bundle.funct3 = instr[14:12];
    bundle.rs1    = instr[19:15];
    bundle.rs2    = instr[24:20];
    bundle.rd     = instr[11:7];

    case (instr[6:0])
      OPC_OP: begin
        bundle.types[T_R] = 1'b1;
        bundle.funct7     = instr[31:25];
      end
      OPC_OP_IMM: begin
        bundle.types[T_I] = 1'b1;
        bundle.imm        = imm_i;
        // Only right shifts carry a meaningful funct7 (SRLI vs SRAI).
        if (instr[14:12] == 3'b101) bundle.funct7 = instr[31:25];
      end
      OPC_LOAD: begin
        bundle.types[T_L] = 1'b1;
        bundle.imm        = imm_i;
      end
      OPC_STORE: begin
        bundle.types[T_S] = 1'b1;
        bundle.imm        = imm_s;
        bundle.rd         = '0;
      end
      OPC_BRANCH: begin
        bundle.types[T_B] = 1'b1;
        bundle.imm        = imm_b;
        bundle.rd         = '0;
      end
      OPC_JAL: begin
        bundle.types[T_J] = 1'b1;
        bundle.imm        = imm_j;
        bundle.rs1        = '0;
      end
      OPC_JALR: begin
        bundle.types[T_J] = 1'b1;
        bundle.types[T_I] = 1'b1;
        bundle.imm        = imm_i;
      end
      OPC_LUI, OPC_AUIPC: begin
        bundle.types[T_U] = 1'b1;
        bundle.imm        = imm_u;
        bundle.rs1        = '0;
      end
      default: bundle.illegal = 1'b1;
    endcase

    if (!(bundle.types[T_R] || bundle.types[T_S] || bundle.types[T_B])) bundle.rs2 = '0;
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32 decode stage: decoder feeding a main register plus one skid entry, so
// IN_READY comes straight from a flop while still sustaining one instruction per cycle.
module rv32_decode_stage
  import rv32_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [31:0]           IN_INSTR,
  input  logic [DATA_WIDTH-1:0] IN_PC,
  input  logic                  FLUSH,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] PC_OUT,
  output logic [DATA_WIDTH-1:0] IMM_OUT,
  output logic [4:0]            RS1_ADDR,
  output logic [4:0]            RS2_ADDR,
  output logic [4:0]            RD_ADDR,
  output logic [6:0]            OPCODE,
  output logic [2:0]            FUNCT3,
  output logic [6:0]            FUNCT7,
  output logic [6:0]            TYPES,
  output logic                  ILLEGAL
);

  decoded_t dec, main_q, skid_q;
  logic     main_valid, skid_valid;
  logic     accept, main_open;

  rv32_decode_comb u_decode (
    .instr  (IN_INSTR),
    .pc     (IN_PC),
    .bundle (dec)
  );

  // Skid occupancy is the only reason to stall, so ready is its flop inverted.
  assign IN_READY  = ~skid_valid;
  assign accept    = IN_VALID & IN_READY;
  assign main_open = ~main_valid | OUT_READY;

  always_ff @(posedge CLK) begin
    // NOTE: state updates use <= so every flop samples pre-edge values.
    if (!RST_N) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      // NOTE: data registers are reset too because outputs must read 0 after reset.
      main_q     <= '0;
      skid_q     <= '0;
    end else if (FLUSH) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_open) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign OUT_VALID = main_valid;
  assign PC_OUT    = main_q.pc;
  assign IMM_OUT   = main_q.imm;
  assign RS1_ADDR  = main_q.rs1;
  assign RS2_ADDR  = main_q.rs2;
  assign RD_ADDR   = main_q.rd;
  assign OPCODE    = main_q.opcode;
  assign FUNCT3    = main_q.funct3;
  assign FUNCT7    = main_q.funct7;
  assign TYPES     = main_q.types;
  assign ILLEGAL   = main_q.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Scoreboard bench for rv32_decode_stage: directed cases plus random traffic
// checked against an arithmetic reference decoder.
module tb_rv32_decode_stage;
  import rv32_pkg::*;

  localparam int BW = $bits(decoded_t);

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IN_INSTR = '0;
  logic [31:0] IN_PC = '0;
  logic        FLUSH = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] PC_OUT, IMM_OUT;
  logic [4:0]  RS1_ADDR, RS2_ADDR, RD_ADDR;
  logic [6:0]  OPCODE, FUNCT7, TYPES;
  logic [2:0]  FUNCT3;
  logic        ILLEGAL;

  int vectors = 0;
  int miscompares = 0;
  decoded_t exp_q[$];
  decoded_t got;

  rv32_decode_stage #(.DATA_WIDTH(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .PC_OUT(PC_OUT), .IMM_OUT(IMM_OUT),
    .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR), .RD_ADDR(RD_ADDR),
    .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7(FUNCT7), .TYPES(TYPES),
    .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  assign got = {PC_OUT, IMM_OUT, RS1_ADDR, RS2_ADDR, RD_ADDR, OPCODE, FUNCT3, FUNCT7, TYPES, ILLEGAL};

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference decoder: immediates built with plain integer arithmetic.
  function automatic decoded_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
    decoded_t    e;
    logic [6:0]  op;
    logic [31:0] i_imm;
    op     = instr[6:0];
    i_imm  = $signed(instr) >>> 20;
    e      = '0;
    e.pc     = pc;
    e.opcode = op;
    e.funct3 = instr[14:12];
    e.rs1    = instr[19:15];
    e.rs2    = instr[24:20];
    e.rd     = instr[11:7];
    e.funct7 = instr[31:25];
    case (op)
      7'h33: e.types = 7'b1000000;
      7'h13: begin e.types = 7'b0100000; e.imm = i_imm; end
      7'h03: begin e.types = 7'b0010000; e.imm = i_imm; end
      7'h23: begin
        e.types = 7'b0001000; e.rd = 0;
        e.imm   = (i_imm & ~32'h1f) | 32'(instr[11:7]);
      end
      7'h63: begin
        e.types = 7'b0000010; e.rd = 0;
        e.imm   = 32'(instr[31]) * 4096 + 32'(instr[7]) * 2048 + 32'(instr[30:25]) * 32
                + 32'(instr[11:8]) * 2 - (instr[31] ? 32'd8192 : 32'd0);
      end
      7'h6F: begin
        e.types = 7'b0000100; e.rs1 = 0;
        e.imm   = 32'(instr[31]) * (1 << 20) + 32'(instr[19:12]) * (1 << 12)
                + 32'(instr[20]) * (1 << 11) + 32'(instr[30:21]) * 2
                - (instr[31] ? 32'(1 << 21) : 32'd0);
      end
      7'h67: begin e.types = 7'b0100100; e.imm = i_imm; end
      7'h37, 7'h17: begin e.types = 7'b0000001; e.imm = instr & 32'hFFFFF000; e.rs1 = 0; end
      default: e.illegal = 1'b1;
    endcase
    if (op != 7'h33 && op != 7'h23 && op != 7'h63) e.rs2 = 0;
    if (!(op == 7'h33 || (op == 7'h13 && instr[14:12] == 3'b101))) e.funct7 = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 8)];
    return r;
  endfunction

  // Stimulus side: record every instruction the DUT will accept at the coming edge.
  always begin
    @(negedge CLK);
    #1;
    if (!RST_N || FLUSH) exp_q.delete();
    else if (IN_VALID && IN_READY) exp_q.push_back(ref_decode(IN_INSTR, IN_PC));
  end

  // Monitor: whatever is presented must match the queue head; pop on transfer.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && FLUSH !== 1'b1 && OUT_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got valid bundle pc %h, expected no output", PC_OUT);
      end else begin
        check("bundle", got, exp_q[0]);
        if (OUT_READY) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send1(input logic [31:0] instr, input logic [31:0] pc);
    step();
    IN_VALID = 1'b1;
    IN_INSTR = instr;
    IN_PC    = pc;
    step();
    IN_VALID = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish within bound");
    $fatal(1, "bench timeout");
  end

  initial begin
    step();
    step();
    @(negedge CLK);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_in_ready", IN_READY, 1);
    check("rst_outputs", got, 0);
    step();
    RST_N     = 1'b1;
    OUT_READY = 1'b1;

    send1(32'hFFF00093, 32'h100);
    check("addi_valid", OUT_VALID, 1);
    check("addi_types", TYPES, 7'b0100000);
    check("addi_imm", IMM_OUT, 32'hFFFFFFFF);
    check("addi_rd", RD_ADDR, 1);
    check("addi_funct7", FUNCT7, 0);
    check("addi_pc", PC_OUT, 32'h100);

    send1(32'h4030D113, 32'h104);
    check("srai_types", TYPES, 7'b0100000);
    check("srai_funct3", FUNCT3, 3'b101);
    check("srai_funct7", FUNCT7, 7'b0100000);
    check("srai_imm", IMM_OUT, 32'h00000403);
    check("srai_rs1", RS1_ADDR, 1);
    check("srai_rs2", RS2_ADDR, 0);

    send1(32'h000280E7, 32'h108);
    check("jalr_types", TYPES, 7'b0100100);
    check("jalr_rs1", RS1_ADDR, 5);
    check("jalr_imm", IMM_OUT, 0);
    send1(32'h008000EF, 32'h10C);
    check("jal_types", TYPES, 7'b0000100);
    check("jal_imm", IMM_OUT, 8);
    send1(32'h123450B7, 32'h110);
    check("lui_types", TYPES, 7'b0000001);
    check("lui_imm", IMM_OUT, 32'h12345000);

    // Backpressure: A to main, B to skid, C stalled until the drain frees skid.
    step();
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1; IN_INSTR = 32'h00100093; IN_PC = 32'h200;
    step();
    IN_INSTR = 32'h00200113; IN_PC = 32'h204;
    step();
    IN_INSTR = 32'h00300193; IN_PC = 32'h208;
    step();
    @(negedge CLK);
    check("bp_in_ready_low", IN_READY, 0);
    check("bp_hold_valid", OUT_VALID, 1);
    check("bp_hold_pc", PC_OUT, 32'h200);
    step();
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("bp_still_low", IN_READY, 0);
    check("bp_stable_pc", PC_OUT, 32'h200);
    step();
    @(negedge CLK);
    check("bp_drain_b", PC_OUT, 32'h204);
    check("bp_ready_back", IN_READY, 1);
    step();
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("bp_drain_c", PC_OUT, 32'h208);
    step();
    @(negedge CLK);
    check("bp_empty", OUT_VALID, 0);

    // Flush with both entries full and input presented.
    step();
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1; IN_INSTR = 32'h00500293; IN_PC = 32'h300;
    step();
    IN_INSTR = 32'h00600313; IN_PC = 32'h304;
    step();
    IN_INSTR = 32'h00700393; IN_PC = 32'h308; FLUSH = 1'b1;
    step();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    @(negedge CLK);
    check("flush_out_valid", OUT_VALID, 0);
    check("flush_in_ready", IN_READY, 1);

    // Flush while ready: the same-cycle input must be dropped.
    step();
    IN_VALID = 1'b1; IN_INSTR = 32'h00800413; IN_PC = 32'h310;
    step();
    IN_INSTR = 32'h00900493; IN_PC = 32'h314; FLUSH = 1'b1;
    step();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    @(negedge CLK);
    check("flush_drop_in", OUT_VALID, 0);
    step();
    OUT_READY = 1'b1;
    send1(32'h00A00513, 32'h400);
    check("post_flush_valid", OUT_VALID, 1);
    check("post_flush_pc", PC_OUT, 32'h400);

    send1(32'h00000000, 32'h500);
    check("illegal_flag", ILLEGAL, 1);
    check("illegal_types", TYPES, 0);
    check("illegal_valid", OUT_VALID, 1);

    // Mid-stream reset with two instructions held.
    step();
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1; IN_INSTR = 32'h00B00593; IN_PC = 32'h600;
    step();
    IN_INSTR = 32'h00C00613; IN_PC = 32'h604;
    step();
    IN_VALID = 1'b0; RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    @(negedge CLK);
    check("midrst_valid", OUT_VALID, 0);
    check("midrst_outputs", got, 0);
    check("midrst_ready", IN_READY, 1);

    for (int n = 0; n < 600; n++) begin
      step();
      IN_VALID  = ($urandom_range(0, 3) != 0);
      IN_INSTR  = rand_instr();
      IN_PC     = $urandom & ~32'h3;
      OUT_READY = ($urandom_range(0, 9) < 7);
      FLUSH     = ($urandom_range(0, 39) == 0);
    end
    step();
    IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    @(negedge CLK);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", OUT_VALID, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
